// File: rtl/led_pattern_sequencer_if.sv
// Pattern-table load port: host (master) pushes one entry per Cfg_valid & Cfg_ready beat.
// Cfg_ready is driven by the sequencer and drops while a sequence is running or starting.
interface led_pattern_sequencer_if #(
  parameter int AW       = 3,
  parameter int NUM_LEDS = 3,
  parameter int DUR_W    = 8
);
  logic                Cfg_valid;
  logic                Cfg_ready;
  logic [AW-1:0]       Cfg_addr;
  logic [NUM_LEDS-1:0] Cfg_pattern;
  logic [DUR_W-1:0]    Cfg_duration;
  logic                Cfg_last;

  modport master (
    output Cfg_valid, Cfg_addr, Cfg_pattern, Cfg_duration, Cfg_last,
    input  Cfg_ready
  );

  modport slave (
    input  Cfg_valid, Cfg_addr, Cfg_pattern, Cfg_duration, Cfg_last,
    output Cfg_ready
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Table-driven LED sequencer; IO_voltage follows Start by 1 cycle, steps last max(dur,1) ticks.
// Table writes are back-pressured (Cfg_ready=0) outside IDLE; define LED_SEQ_LOOP_EN to repeat forever.
module led_pattern_sequencer #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int TICK_MS         = 10,
  parameter int NUM_LEDS        = 3,
  parameter int DEPTH           = 8,
  parameter int DUR_W           = 8,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  led_pattern_sequencer_if.slave cfg,
  input  logic                  Start,
  input  logic                  Stop,
  output logic                  Busy,
  output logic                  Done,
  output logic [AW-1:0]         Step_index,
  output logic [NUM_LEDS-1:0]   IO_voltage
);

  localparam int TICK_COUNT = (CLOCK_FREQUENCY / 1000) * TICK_MS - 1;
  localparam int PW         = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [NUM_LEDS-1:0] pattern;
    logic [DUR_W-1:0]    duration;
  } entry_t;

  entry_t              tbl [DEPTH];
  state_t              state_q, state_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [DUR_W-1:0]    dcnt_q, dcnt_d;
  logic [AW-1:0]       step_d;
  logic [NUM_LEDS-1:0] io_d;
  logic                done_d;
  logic [AW-1:0]       last_idx_q;
  logic                last_valid_q;

  logic                cfg_wr;
  entry_t              cur;
  logic [AW-1:0]       nxt_step;
  logic [DUR_W-1:0]    eff_dur;
  logic                tick;
  logic                step_end;
  logic                at_last;

  assign cfg.Cfg_ready = (state_q == IDLE) & ~Start;
  assign cfg_wr        = cfg.Cfg_valid & cfg.Cfg_ready;
  assign Busy          = (state_q == RUN);

  assign cur      = tbl[Step_index];
  assign nxt_step = Step_index + AW'(1);
  assign eff_dur  = (cur.duration == '0) ? DUR_W'(1) : cur.duration;
  assign tick     = (pcnt_q == PW'(TICK_COUNT));
  assign step_end = tick & (dcnt_q == eff_dur - DUR_W'(1));
  assign at_last  = (Step_index == last_idx_q);

  // Table storage has no reset; contents are only meaningful once written.
  always_ff @(posedge Clock) begin
    if (cfg_wr)
      tbl[cfg.Cfg_addr] <= entry_t'{pattern: cfg.Cfg_pattern, duration: cfg.Cfg_duration};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
    end else if (cfg_wr && cfg.Cfg_last) begin
      last_idx_q   <= cfg.Cfg_addr;
      last_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      dcnt_q     <= '0;
      Step_index <= '0;
      IO_voltage <= '0;
      Done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      dcnt_q     <= dcnt_d;
      Step_index <= step_d;
      IO_voltage <= io_d;
      Done       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    step_d  = Step_index;
    io_d    = IO_voltage;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && last_valid_q && !Stop) begin
          state_d = RUN;
          pcnt_d  = '0;
          dcnt_d  = '0;
          step_d  = '0;
          io_d    = tbl[0].pattern;
        end
      end
      RUN: begin
        // Stop wins over any step expiry landing on the same edge.
        if (Stop) begin
          state_d = IDLE;
          pcnt_d  = '0;
          dcnt_d  = '0;
          step_d  = '0;
          io_d    = '0;
        end else begin
          pcnt_d = tick ? '0 : pcnt_q + PW'(1);
          if (step_end) begin
            dcnt_d = '0;
            if (at_last) begin
`ifdef LED_SEQ_LOOP_EN
              step_d  = '0;
              io_d    = tbl[0].pattern;
`else
              state_d = IDLE;
              pcnt_d  = '0;
              step_d  = '0;
              io_d    = '0;
              done_d  = 1'b1;
`endif
            end else begin
              step_d = nxt_step;
              io_d   = tbl[nxt_step].pattern;
            end
          end else if (tick) begin
            dcnt_d = dcnt_q + DUR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer at 4 cycles per tick; inputs change and outputs
// are sampled on the falling edge. Build with LED_SEQ_LOOP_EN to exercise the looping variant.
module tb_led_pattern_sequencer;
  localparam int AW = 3;

  logic          Clock;
  logic          Reset_n;
  logic          Start;
  logic          Stop;
  logic          Busy;
  logic          Done;
  logic [AW-1:0] Step_index;
  logic [2:0]    IO_voltage;

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer_if #(.AW(AW), .NUM_LEDS(3), .DUR_W(8)) cfg_if ();

  led_pattern_sequencer #(
    .CLOCK_FREQUENCY(4000),
    .TICK_MS        (1),
    .NUM_LEDS       (3),
    .DEPTH          (8),
    .DUR_W          (8)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .cfg       (cfg_if.slave),
    .Start     (Start),
    .Stop      (Stop),
    .Busy      (Busy),
    .Done      (Done),
    .Step_index(Step_index),
    .IO_voltage(IO_voltage)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [2:0] pat,
                           input logic [7:0] dur, input logic last);
    cfg_if.Cfg_valid    = 1'b1;
    cfg_if.Cfg_addr     = addr;
    cfg_if.Cfg_pattern  = pat;
    cfg_if.Cfg_duration = dur;
    cfg_if.Cfg_last     = last;
    @(negedge Clock);
    cfg_if.Cfg_valid    = 1'b0;
    cfg_if.Cfg_last     = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic pulse_stop();
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
  endtask

  task automatic reset_mid_step();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_io", IO_voltage, 3'b000);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_step", Step_index, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    Reset_n             = 1'b0;
    Start               = 1'b0;
    Stop                = 1'b0;
    cfg_if.Cfg_valid    = 1'b0;
    cfg_if.Cfg_addr     = '0;
    cfg_if.Cfg_pattern  = '0;
    cfg_if.Cfg_duration = '0;
    cfg_if.Cfg_last     = 1'b0;
    cycles(3);
    Reset_n = 1'b1;
    @(negedge Clock);

    chk("rst_io", IO_voltage, 3'b000);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_step", Step_index, 0);
    chk("rst_ready", cfg_if.Cfg_ready, 1'b1);

    cfg_write(3'd0, 3'b101, 8'd2, 1'b0);
    cfg_write(3'd1, 3'b010, 8'd1, 1'b1);

`ifdef LED_SEQ_LOOP_EN
    // 101 for 8 cycles, 010 for 4, repeating; Done stays low.
    pulse_start();
    for (int i = 0; i < 36; i++) begin
      chk("loop_io", IO_voltage, ((i % 12) < 8) ? 3'b101 : 3'b010);
      chk("loop_done", Done, 1'b0);
      chk("loop_busy", Busy, 1'b1);
      @(negedge Clock);
    end
    cycles(3);
    reset_mid_step();
    chk("loop_post_rst_busy", Busy, 1'b0);
`else
    // Test 1: two-step sequence ending with a Done pulse.
    pulse_start();
    for (int i = 0; i < 13; i++) begin
      chk("seq_io", IO_voltage, (i < 8) ? 3'b101 : ((i < 12) ? 3'b010 : 3'b000));
      chk("seq_step", Step_index, (i >= 8 && i < 12) ? 1 : 0);
      chk("seq_busy", Busy, (i < 12) ? 1'b1 : 1'b0);
      chk("seq_done", Done, (i == 12) ? 1'b1 : 1'b0);
      @(negedge Clock);
    end
    chk("seq_done_clear", Done, 1'b0);

    // Async reset mid-step, which also forgets the last marker.
    pulse_start();
    cycles(3);
    reset_mid_step();

    // Test 2: Start with no last entry is ignored.
    pulse_start();
    chk("nolast_busy", Busy, 1'b0);
    chk("nolast_io", IO_voltage, 3'b000);
    cycles(2);
    chk("nolast_busy2", Busy, 1'b0);

    // Test 3: zero duration behaves as one tick.
    cfg_write(3'd0, 3'b110, 8'd0, 1'b1);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("dur0_io", IO_voltage, (i < 4) ? 3'b110 : 3'b000);
      chk("dur0_done", Done, (i == 4) ? 1'b1 : 1'b0);
      @(negedge Clock);
    end

    // Test 4: Stop mid-step, then Start together with Stop in IDLE.
    cfg_write(3'd0, 3'b101, 8'd2, 1'b0);
    cfg_write(3'd1, 3'b010, 8'd1, 1'b1);
    pulse_start();
    cycles(4);
    chk("stop_pre_io", IO_voltage, 3'b101);
    pulse_stop();
    chk("stop_io", IO_voltage, 3'b000);
    chk("stop_busy", Busy, 1'b0);
    chk("stop_done", Done, 1'b0);
    chk("stop_step", Step_index, 0);
    Start = 1'b1;
    Stop  = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Stop  = 1'b0;
    chk("startstop_busy", Busy, 1'b0);
    chk("startstop_io", IO_voltage, 3'b000);
    cycles(1);
    chk("startstop_done", Done, 1'b0);

    // Test 5: writes during RUN are refused and leave the table alone.
    pulse_start();
    cfg_if.Cfg_valid    = 1'b1;
    cfg_if.Cfg_addr     = 3'd0;
    cfg_if.Cfg_pattern  = 3'b111;
    cfg_if.Cfg_duration = 8'd5;
    #1;
    chk("run_ready", cfg_if.Cfg_ready, 1'b0);
    @(negedge Clock);
    cfg_if.Cfg_valid = 1'b0;
    pulse_stop();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      chk("tbl_keep_io", IO_voltage, (i < 8) ? 3'b101 : 3'b010);
      @(negedge Clock);
    end
    pulse_stop();

    // Write presented together with Start: refused, sequence starts.
    cfg_if.Cfg_valid    = 1'b1;
    cfg_if.Cfg_addr     = 3'd0;
    cfg_if.Cfg_pattern  = 3'b111;
    cfg_if.Cfg_duration = 8'd1;
    Start               = 1'b1;
    #1;
    chk("start_ready", cfg_if.Cfg_ready, 1'b0);
    @(negedge Clock);
    Start            = 1'b0;
    cfg_if.Cfg_valid = 1'b0;
    chk("wstart_busy", Busy, 1'b1);
    chk("wstart_io", IO_voltage, 3'b101);
    cycles(4);
    chk("wstart_dur_io", IO_voltage, 3'b101);
    pulse_stop();
    chk("wstart_stop_busy", Busy, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
